// File: rtl/imem_loader.sv
// Boot loader: turns a length-prefixed host byte stream into 32-bit instruction memory writes.
// Define IMEM_LOADER_CSUM_EN to require a trailing XOR checksum byte after the data bytes.
module imem_loader #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] words_written
);

    localparam int unsigned LEN_W  = 16;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
`ifdef IMEM_LOADER_CSUM_EN
        ,
        CSUM   = 3'd6
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          len_lo_q, len_lo_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
    logic                last_q, last_d;
    logic                we_q, we_d;
    logic [WORD_W-1:0]   waddr_q, waddr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic [LEN_W-1:0]    words_q, words_d;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    logic                in_ready_c;
    logic                xfer_c;
    logic [LEN_W-1:0]    len_c;
    logic                go_done_c;
    logic                go_err_c;

    // Byte acceptance is a pure decode of the current state.
    always_comb begin
        in_ready_c = 1'b0;
        case (state_q)
            LEN_LO, LEN_HI, DATA: in_ready_c = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
            CSUM:                 in_ready_c = 1'b1;
`endif
            default:              in_ready_c = 1'b0;
        endcase
    end

    assign xfer_c = in_valid && in_ready_c;
    assign len_c  = {in_data, len_lo_q};

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        word_idx_d = word_idx_q;
        last_d     = 1'b0;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        cpu_hold_d = cpu_hold_q;
        words_d    = words_q;
`ifdef IMEM_LOADER_CSUM_EN
        csum_d     = csum_q;
`endif
        go_done_c  = 1'b0;
        go_err_c   = 1'b0;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d    = LEN_LO;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    words_d    = '0;
                    cpu_hold_d = 1'b1;
                    busy_d     = 1'b1;
                    byte_cnt_d = '0;
                    word_idx_d = '0;
`ifdef IMEM_LOADER_CSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            LEN_LO: begin
                if (xfer_c) begin
                    len_lo_d = in_data;
                    state_d  = LEN_HI;
                end
            end
            LEN_HI: begin
                if (xfer_c) begin
                    len_d = len_c;
                    if (len_c == '0) begin
`ifdef IMEM_LOADER_CSUM_EN
                        state_d = CSUM;
`else
                        go_done_c = 1'b1;
`endif
                    end else if (len_c > LEN_W'(DEPTH)) begin
                        go_err_c = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (last_q) begin
                    // Final write cycle; a byte arriving now can only be the checksum.
`ifdef IMEM_LOADER_CSUM_EN
                    if (xfer_c) begin
                        if (in_data == csum_q) go_done_c = 1'b1;
                        else                   go_err_c  = 1'b1;
                    end else begin
                        state_d = CSUM;
                    end
`else
                    go_done_c = 1'b1;
`endif
                end else if (xfer_c) begin
                    shift_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
                    csum_d = csum_q ^ in_data;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        we_d       = 1'b1;
                        waddr_d    = WORD_W'({word_idx_q, 2'b00});
                        wdata_d    = shift_d;
                        word_idx_d = word_idx_q + ADDR_W'(1);
                        words_d    = words_q + 16'd1;
                        last_d     = ((words_q + 16'd1) == len_q);
                    end
                end
            end
`ifdef IMEM_LOADER_CSUM_EN
            CSUM: begin
                if (xfer_c) begin
                    if (in_data == csum_q) go_done_c = 1'b1;
                    else                   go_err_c  = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (go_done_c) begin
            state_d    = DONE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
        end
        if (go_err_c) begin
            state_d    = ERR;
            busy_d     = 1'b0;
            err_d      = 1'b1;
            cpu_hold_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_lo_q   <= '0;
            len_q      <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            word_idx_q <= '0;
            last_q     <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpu_hold_q <= 1'b1;
            words_q    <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            word_idx_q <= word_idx_d;
            last_q     <= last_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cpu_hold_q <= cpu_hold_d;
            words_q    <= words_d;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign in_ready      = in_ready_c;
    assign we            = we_q;
    assign waddr         = waddr_q;
    assign wdata         = wdata_q;
    assign cpu_hold      = cpu_hold_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign words_written = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: frames built from a byte-level model,
// expected memory writes queued at issue time and checked by an independent write monitor.
module tb_imem_loader;

    localparam int unsigned DEPTH = 256;
`ifdef IMEM_LOADER_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic        clk, rst_n, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, we, cpu_hold, busy, done, err;
    logic [31:0] waddr, wdata;
    logic [15:0] words_written;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] fixed_w[$];
    int          checks = 0;
    int          errors = 0;

    imem_loader #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .we(we), .waddr(waddr),
        .wdata(wdata), .cpu_hold(cpu_hold), .busy(busy), .done(done),
        .err(err), .words_written(words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Write monitor: every we pulse must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (rst_n && we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", waddr, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("waddr", waddr, e.addr);
                check("wdata", wdata, e.data);
                check("words_at_write", 32'(words_written), (e.addr >> 2) + 32'd1);
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
        check({tag, "_we"}, 32'(we), 0);
        check({tag, "_waddr"}, waddr, 0);
        check({tag, "_wdata"}, wdata, 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_words"}, 32'(words_written), 0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 1);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        int n;
        @(negedge clk);
        if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            repeat ($urandom_range(3, 1)) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check("in_ready_timeout", 32'(in_ready), 1);
            in_valid = 1'b0;
        end
    endtask

    task automatic end_frame();
        @(negedge clk) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("busy_release", 32'(busy), 0);
    endtask

    // Model: frame = len LE, then len words LSB-first (plus XOR byte when checksummed).
    task automatic run_frame(input int len, input int gap_pct, input bit bad_csum, input bit mid_start);
        logic [7:0]  q[$];
        logic [7:0]  x;
        logic [31:0] w;
        bit          ok, exp_done;
        int          exp_words;
        x = 8'h00;
        q.push_back(8'(len));
        q.push_back(8'(len >> 8));
        ok        = (len <= DEPTH);
        exp_words = ok ? len : 0;
        if (ok) begin
            for (int i = 0; i < len; i++) begin
                w = (i < fixed_w.size()) ? fixed_w[i] : $urandom;
                exp_q.push_back('{addr: 32'(i * 4), data: w});
                for (int k = 0; k < 4; k++) begin
                    q.push_back(w[8*k +: 8]);
                    x ^= w[8*k +: 8];
                end
            end
        end
        exp_done = ok;
        if (CSUM_EN && ok) begin
            q.push_back(bad_csum ? (x ^ 8'h73) : x);
            exp_done = !bad_csum;
        end
        pulse_start();
        fork
            begin
                foreach (q[i]) send_byte(q[i], gap_pct);
                end_frame();
            end
            begin
                if (mid_start) begin
                    repeat (8) @(negedge clk);
                    start = 1'b1;
                    @(negedge clk) start = 1'b0;
                end
            end
        join
        wait_idle();
        check("done", 32'(done), 32'(exp_done));
        check("err", 32'(err), 32'(!exp_done));
        check("cpu_hold", 32'(cpu_hold), 32'(!exp_done));
        check("words_written", 32'(words_written), 32'(exp_words));
        check("in_ready_idle", 32'(in_ready), 0);
        check("writes_drained", 32'(exp_q.size()), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, r;
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_vals("idle");

        fixed_w = '{32'h0000_0013, 32'h0010_0093};
        run_frame(2, 0, 1'b0, 1'b0);
        fixed_w.delete();

        run_frame(257, 0, 1'b0, 1'b0);
        run_frame(0, 0, 1'b0, 1'b0);

        fixed_w = '{32'hDEAD_BEEF, 32'h1234_5678, 32'h0BAD_F00D};
        run_frame(3, 0, 1'b0, 1'b0);
        run_frame(3, 40, 1'b0, 1'b1);
        fixed_w.delete();

        // Abandon a load partway through the second word.
        pulse_start();
        exp_q.push_back('{addr: 32'h0, data: 32'hCAFE_F00D});
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        send_byte(8'h0D, 0);
        send_byte(8'hF0, 0);
        send_byte(8'hFE, 0);
        send_byte(8'hCA, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        end_frame();
        repeat (3) @(negedge clk);
        check("partial_words", 32'(words_written), 1);
        check("partial_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_reset");
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("post_reset");
        check("reset_drained", 32'(exp_q.size()), 0);

        run_frame(256, 0, 1'b0, 1'b0);
        run_frame(1, 20, 1'b0, 1'b0);

        for (int t = 0; t < 12; t++) begin
            r = $urandom_range(9);
            if (r == 0)      len = 0;
            else if (r == 1) len = $urandom_range(300, 257);
            else             len = $urandom_range(8, 1);
            run_frame(len, $urandom_range(60), CSUM_EN ? 1'($urandom_range(1)) : 1'b0, 1'($urandom_range(1)));
        end

        if (CSUM_EN) begin
            fixed_w = '{32'h0000_0073};
            run_frame(1, 0, 1'b0, 1'b0);
            run_frame(1, 0, 1'b1, 1'b0);
            fixed_w.delete();
        end

        repeat (3) @(negedge clk);
        check("final_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
